// File: rtl/nor_filt_n.sv
// N-input NOR with input synchroniser, per-bit polarity mask, glitch filter on the result,
// registered edge pulses, sticky fall flag and saturating fall counter.
module nor_filt_n #(
  parameter int N_IN        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYC    = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             CELV,
  input  logic             CELG,
  input  logic             SUB,
  input  logic [N_IN-1:0]  i,
  input  logic [N_IN-1:0]  inv_mask,
  input  logic             en,
  input  logic             clr,
  output logic             o_raw,
  output logic             o,
  output logic             fall_pulse,
  output logic             rise_pulse,
  output logic             sticky,
  output logic [CNT_W-1:0] evt_cnt
);

  localparam logic [7:0]       FILT_LAST = 8'(FILT_CYC - 1);
  localparam logic [CNT_W-1:0] EVT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] EVT_MAX   = '1;

  // Supply pins exist only so the brick-level netlist connects unchanged.
  logic unused_supply;
  assign unused_supply = &{CELV, CELG, SUB};

  logic [N_IN-1:0] s;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign s = i;
  end else begin : g_sync
    logic [N_IN-1:0] sync_q [SYNC_STAGES];

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      end else begin
        sync_q[0] <= i;
        for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      end
    end

    assign s = sync_q[SYNC_STAGES-1];
  end

  logic             o_raw_q, o_raw_d;
  logic             o_q, o_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             fall_q, fall_d;
  logic             rise_q, rise_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] evt_q, evt_d;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    o_raw_d  = ~|(s ^ inv_mask);
    o_d      = o_q;
    cnt_d    = '0;
    fall_d   = 1'b0;
    rise_d   = 1'b0;
    sticky_d = sticky_q;
    evt_d    = evt_q;

    // Disagreement must persist FILT_CYC cycles; one cycle of agreement restarts it.
    if (en && (o_raw_q != o_q)) begin
      if (cnt_q == FILT_LAST) begin
        o_d    = o_raw_q;
        fall_d = o_q;
        rise_d = ~o_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end

    if (clr) begin
      sticky_d = 1'b0;
      evt_d    = '0;
    end
    // A fall coinciding with clr still counts as the first event after the clear.
    if (fall_d) begin
      sticky_d = 1'b1;
      if (clr)                   evt_d = EVT_ONE;
      else if (evt_q != EVT_MAX) evt_d = evt_q + EVT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_raw_q  <= 1'b1;
      o_q      <= 1'b1;
      cnt_q    <= '0;
      fall_q   <= 1'b0;
      rise_q   <= 1'b0;
      sticky_q <= 1'b0;
      evt_q    <= '0;
    end else begin
      o_raw_q  <= o_raw_d;
      o_q      <= o_d;
      cnt_q    <= cnt_d;
      fall_q   <= fall_d;
      rise_q   <= rise_d;
      sticky_q <= sticky_d;
      evt_q    <= evt_d;
    end
  end

  assign o_raw      = o_raw_q;
  assign o          = o_q;
  assign fall_pulse = fall_q;
  assign rise_pulse = rise_q;
  assign sticky     = sticky_q;
  assign evt_cnt    = evt_q;

endmodule

// File: tb/tb_nor_filt_n.sv
// Randomised and directed bench for nor_filt_n; a default-width and a 2-bit-counter instance
// share stimulus and are compared every cycle against a behavioural model.
module tb_nor_filt_n;

  localparam int N      = 4;
  localparam int SS     = 2;
  localparam int FC     = 4;
  localparam int CW     = 8;
  localparam int CW_SAT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] i_in = '0;
  logic [N-1:0] mask = '0;
  logic en = 1'b1;
  logic clr = 1'b0;

  logic a_raw, a_o, a_fall, a_rise, a_sticky;
  logic [CW-1:0] a_evt;
  logic b_raw, b_o, b_fall, b_rise, b_sticky;
  logic [CW_SAT-1:0] b_evt;

  always #5 clk = ~clk;

  nor_filt_n #(.N_IN(N), .SYNC_STAGES(SS), .FILT_CYC(FC), .CNT_W(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .CELV(1'b1), .CELG(1'b0), .SUB(1'b0),
    .i(i_in), .inv_mask(mask), .en(en), .clr(clr),
    .o_raw(a_raw), .o(a_o), .fall_pulse(a_fall), .rise_pulse(a_rise),
    .sticky(a_sticky), .evt_cnt(a_evt));

  nor_filt_n #(.N_IN(N), .SYNC_STAGES(SS), .FILT_CYC(FC), .CNT_W(CW_SAT)) u_sat (
    .clk(clk), .rst_n(rst_n), .CELV(1'b1), .CELG(1'b0), .SUB(1'b0),
    .i(i_in), .inv_mask(mask), .en(en), .clr(clr),
    .o_raw(b_raw), .o(b_o), .fall_pulse(b_fall), .rise_pulse(b_rise),
    .sticky(b_sticky), .evt_cnt(b_evt));

  // Behavioural reference: history of sampled inputs, disagreement run length, event tallies.
  logic [N-1:0] m_hist[$];
  bit m_raw, m_o, m_fall, m_rise, m_sticky;
  int m_run, m_evt, m_evt_sat;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hist.delete();
    repeat (SS) m_hist.push_back('0);
    m_raw = 1; m_o = 1; m_fall = 0; m_rise = 0; m_sticky = 0;
    m_run = 0; m_evt = 0; m_evt_sat = 0;
  endtask

  function automatic bit fall_next();
    return en && (m_raw != m_o) && (m_run == FC - 1) && m_o;
  endfunction

  task automatic model_edge();
    logic [N-1:0] s;
    bit nxt_raw;
    s = (SS == 0) ? i_in : m_hist[SS-1];
    nxt_raw = ~|(s ^ mask);
    m_fall = 0;
    m_rise = 0;
    if (en && m_raw != m_o) begin
      if (m_run + 1 == FC) begin
        m_fall = m_o;
        m_rise = !m_o;
        m_o = m_raw;
        m_run = 0;
      end else begin
        m_run++;
      end
    end else begin
      m_run = 0;
    end
    if (clr) begin
      m_sticky = 0; m_evt = 0; m_evt_sat = 0;
    end
    if (m_fall) begin
      m_sticky = 1;
      if (m_evt < (1 << CW) - 1) m_evt++;
      if (m_evt_sat < (1 << CW_SAT) - 1) m_evt_sat++;
    end
    m_raw = nxt_raw;
    m_hist.push_front(i_in);
    if (m_hist.size() > SS) void'(m_hist.pop_back());
  endtask

  task automatic compare_all();
    check("o_raw", 32'(a_raw), 32'(m_raw));
    check("o", 32'(a_o), 32'(m_o));
    check("fall_pulse", 32'(a_fall), 32'(m_fall));
    check("rise_pulse", 32'(a_rise), 32'(m_rise));
    check("sticky", 32'(a_sticky), 32'(m_sticky));
    check("evt_cnt", 32'(a_evt), 32'(m_evt));
    check("sat_o", 32'(b_o), 32'(m_o));
    check("sat_evt_cnt", 32'(b_evt), 32'(m_evt_sat));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    int first_raw, first_o, pulse_at, k, evt_before;
    bit saw_fall, o_dropped, raw_dipped, got_coinc;

    // Reset values
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;
    repeat (5) step();

    // Latency of a fall: o_raw at SS+1 edges, o and fall_pulse at SS+1+FC edges
    i_in = 4'b0100;
    first_raw = -1; first_o = -1; pulse_at = -1;
    for (int e = 1; e <= 12; e++) begin
      step();
      if (first_raw < 0 && a_raw == 1'b0) first_raw = e;
      if (first_o < 0 && a_o == 1'b0) first_o = e;
      if (a_fall) pulse_at = e;
    end
    check("lat_raw_fall", 32'(first_raw), 32'(SS + 1));
    check("lat_o_fall", 32'(first_o), 32'(SS + 1 + FC));
    check("lat_fall_pulse", 32'(pulse_at), 32'(SS + 1 + FC));
    check("lat_sticky", 32'(a_sticky), 32'd1);
    check("lat_evt", 32'(a_evt), 32'd1);

    // Latency of the return to 1
    i_in = 4'b0000;
    first_o = -1; pulse_at = -1;
    for (int e = 1; e <= 12; e++) begin
      step();
      if (first_o < 0 && a_o == 1'b1) first_o = e;
      if (a_rise) pulse_at = e;
    end
    check("lat_o_rise", 32'(first_o), 32'(SS + 1 + FC));
    check("lat_rise_pulse", 32'(pulse_at), 32'(SS + 1 + FC));

    // Glitch of FC-1 cycles must not reach o
    evt_before = m_evt;
    saw_fall = 0; o_dropped = 0; raw_dipped = 0;
    i_in = 4'b0001;
    for (int e = 0; e < 12; e++) begin
      if (e == FC - 1) i_in = 4'b0000;
      step();
      if (a_fall) saw_fall = 1;
      if (!a_o) o_dropped = 1;
      if (!a_raw) raw_dipped = 1;
    end
    check("glitch_raw_dip", 32'(raw_dipped), 32'd1);
    check("glitch_o_held", 32'(o_dropped), 32'd0);
    check("glitch_no_pulse", 32'(saw_fall), 32'd0);
    check("glitch_evt", 32'(a_evt), 32'(evt_before));

    // Polarity mask
    mask = 4'b0001;
    repeat (10) step();
    check("mask_o_low", 32'(a_o), 32'd0);
    i_in = 4'b0001;
    repeat (10) step();
    check("mask_o_high", 32'(a_o), 32'd1);
    mask = 4'b0000;
    i_in = 4'b0000;
    repeat (10) step();

    // Saturation of the 2-bit counter, then clr coincident with a fall, then clr alone
    got_coinc = 0;
    for (int f = 0; f < 6; f++) begin
      i_in = 4'b0010;
      for (int e = 0; e < 12; e++) begin
        clr = (f == 5) && fall_next();
        if (clr) got_coinc = 1;
        step();
        clr = 1'b0;
      end
      if (f == 4) check("sat_evt_3", 32'(b_evt), 32'd3);
      i_in = 4'b0000;
      repeat (10) step();
    end
    check("coinc_applied", 32'(got_coinc), 32'd1);
    check("coinc_evt_1", 32'(b_evt), 32'd1);
    check("coinc_sticky", 32'(b_sticky), 32'd1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_evt_0", 32'(b_evt), 32'd0);
    check("clr_sticky_0", 32'(a_sticky), 32'd0);

    // Enable: o frozen while en=0, follows FC edges after en returns
    en = 1'b0;
    i_in = 4'b1000;
    saw_fall = 0;
    repeat (20) begin
      step();
      if (a_fall || a_rise) saw_fall = 1;
    end
    check("en0_o_frozen", 32'(a_o), 32'd1);
    check("en0_raw_low", 32'(a_raw), 32'd0);
    check("en0_no_pulse", 32'(saw_fall), 32'd0);
    en = 1'b1;
    k = -1;
    for (int e = 1; e <= 10; e++) begin
      step();
      if (k < 0 && a_o == 1'b0) k = e;
    end
    check("en1_latency", 32'(k), 32'(FC));

    // Asynchronous reset while a filter count is pending
    i_in = 4'b0000;
    repeat (12) step();
    i_in = 4'b0001;
    k = 0;
    while (!(m_raw != m_o && m_run == 2) && k < 20) begin
      step();
      k++;
    end
    check("rst_pending_reached", 32'(k < 20), 32'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;
    repeat (SS + FC + 4) step();

    // Randomised run: held inputs with occasional changes of varied length
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 5) == 0) i_in = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      if ($urandom_range(0, 60) == 0) mask = 4'($urandom);
      en = ($urandom_range(0, 15) != 0);
      clr = ($urandom_range(0, 31) == 0);
      step();
    end
    clr = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
